// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scanner with double-buffered data,
// ghost blanking, leading-zero suppression, per-digit blink and hex decode.
module display_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int DIV          = 1000,
    parameter int BLANK        = 2,
    parameter int BLINK_FRAMES = 64,
    parameter bit SEG_ACT_LOW  = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [4*N_DIGITS-1:0]       LedData,
    input  logic                        load,
    input  logic                        blank_lz,
    input  logic [N_DIGITS-1:0]         blink_mask,
    input  logic [N_DIGITS-1:0]         dp_mask,
    output logic [$clog2(N_DIGITS)-1:0] select,
    output logic [N_DIGITS-1:0]         an,
    output logic [3:0]                  num,
    output logic [7:0]                  seg,
    output logic                        frame_tick
);
    localparam int SW = $clog2(N_DIGITS);
    localparam int PW = $clog2(DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [7:0] SEG_OFF = {8{SEG_ACT_LOW}};
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{SEG_ACT_LOW}};

    logic [PW-1:0]         presc;
    logic [4*N_DIGITS-1:0] pending, shadow;
    logic                  pend_valid;
    logic [FW-1:0]         fcnt;
    logic                  phase;
    logic                  slot_tick, last_digit, fwrap, run, blanked;
    logic [3:0]            dig;
    logic [6:0]            glyph;
    logic [N_DIGITS-1:0]   lz, onehot;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign slot_tick  = presc == PW'(DIV - 1);
    assign last_digit = select == SW'(N_DIGITS - 1);
    assign fwrap      = fcnt == FW'(BLINK_FRAMES - 1);
    assign dig        = 4'(shadow >> {select, 2'b00});
    assign glyph      = hex7(dig);
    assign onehot     = N_DIGITS'(1) << select;

    // lz[i]: shadow digits N_DIGITS-1 down to i are all zero
    always_comb begin
        run = 1'b1;
        lz  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run   = run && (shadow[4*i +: 4] == 4'd0);
            lz[i] = run;
        end
    end

    assign blanked = (blank_lz && select != '0 && lz[select]) || (blink_mask[select] && phase);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc      <= '0;
            select     <= '0;
            frame_tick <= 1'b0;
            pending    <= '0;
            shadow     <= '0;
            pend_valid <= 1'b0;
            fcnt       <= '0;
            phase      <= 1'b0;
            num        <= '0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
        end else begin
            presc      <= slot_tick ? '0 : presc + 1'b1;
            select     <= slot_tick ? (last_digit ? '0 : select + 1'b1) : select;
            frame_tick <= slot_tick && last_digit;
            if (load)
                pending <= LedData;
            // shadow swaps only at the frame boundary so a frame never mixes old and new data
            if (frame_tick && pend_valid)
                shadow <= pending;
            pend_valid <= load || (pend_valid && !frame_tick);
            if (frame_tick) begin
                fcnt  <= fwrap ? '0 : fcnt + 1'b1;
                phase <= fwrap ? ~phase : phase;
            end
            num <= dig;
            seg <= SEG_OFF ^ {dp_mask[select], blanked ? 7'h00 : glyph};
            an  <= presc < PW'(BLANK) ? AN_OFF : AN_OFF ^ onehot;
        end
    end
endmodule
